pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Owns the architectural fetch PC register and sequences its update every cycle: sequential increment, stall hold, branch/jump redirect, and halt. Consumes resolved branchTake/brAddr and jump-address results from the execute stage and produces fetch PC plus pipeline flush controls. Sits between fetch and the execute-stage branch/jump resolution logic; the hazard unit supplies the stall.

Parameters:
PC_WIDTH, 16, width of PC and target addresses
FLUSH_DEPTH, 2, younger-instruction bubble cycles after a redirect (1..7)
RESET_PC, 16'h0000, PC value loaded on reset

Ports:
clk  input  1  system clock; one clock domain
rst  input  1  asynchronous, active-high reset
stall  input  1  hazard stall; hold PC and fetch
branchTake  input  1  execute-stage conditional branch taken
brAddr  input  PC_WIDTH  branch target
jumpTake  input  1  execute-stage J/JR/JAL/JALR resolved
jumpAddr  input  PC_WIDTH  jump target
halt  input  1  HALT instruction committed
pc  output  PC_WIDTH  current fetch PC
pcPlus2  output  PC_WIDTH  pc + 2, modulo 2^PC_WIDTH
flush  output  1  squash IF/ID and ID/EX contents this cycle
fetchEn  output  1  fetch valid this cycle
halted  output  1  in HALTED state
err  output  1  sticky sequencing error

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, state=RUN, flush count=0, flush=0, fetchEn=0 while rst is high, halted=0, err=0. First fetchEn=1 is in the first cycle after rst deasserts.
- States: RUN, FLUSH, HALTED. 3-bit flush counter.
- Next-PC priority, evaluated each rising edge: redirect > halt > stall > increment.
- redirect = branchTake | jumpTake. Target = jumpAddr if jumpTake, else brAddr.
- On redirect (from RUN or FLUSH): pc <= target; state <= FLUSH; counter <= FLUSH_DEPTH-1. A redirect overrides stall in the same cycle.
- flush=1 combinationally in the redirect cycle, and in FLUSH while counter>0.
- FLUSH: pc increments normally unless stalled. Counter decrements on non-stall cycles. Return to RUN when the counter reaches 0. A redirect in FLUSH reloads the counter.
- halt (no redirect that cycle): pc held; state <= HALTED. A halt coincident with a redirect is dropped, because it comes from the wrong path.
- HALTED: pc frozen, fetchEn=0, flush=0, halted=1. All inputs are ignored until rst.
- stall, no redirect/halt: pc held, fetchEn=1, counter frozen.
- Otherwise: pc <= pc + 2. Wrap from 16'hFFFE to 16'h0000 is silent.
- fetchEn=1 in RUN/FLUSH when not in reset.
- err is set (sticky until rst) when branchTake and jumpTake are both 1 in the same cycle. In that case jump wins.
- Outputs pc, halted and err are registered. pcPlus2, flush and fetchEn are combinational from state and inputs.

Optional Feature:
PC_SEQ_ALIGN_CHECK_EN
- Defined: a redirect whose selected target has bit 0 = 1 sets err (sticky). The target is still loaded with bit 0 forced to 0.
- Undefined: the target is loaded unmodified and alignment is not checked.

Decomposition:
- Shared package/include: state encodings (RUN=2'b00, FLUSH=2'b01, HALTED=2'b10), RESET_PC default, instruction size constant 2.
- Sub-module: the existing cla_16b computes pcPlus2.
- One natural sub-module, pc_seq_flush_ctr: the down-counter with load, decrement-enable and zero flag.
- PC register and next-PC mux stay in the top.

Test Plan:
- Reset, then 4 free-run cycles → pc = 0000, 0002, 0004, 0006; flush=0; fetchEn=1.
- At pc=0006, branchTake=1, brAddr=0040 → next pc=0040. flush=1 in the redirect cycle plus 1 more (FLUSH_DEPTH=2), then RUN.
- stall=1 for 3 cycles at pc=0010 → pc held at 0010. Stall + jumpTake (jumpAddr=0100) in the same cycle → pc=0100, flush=1.
- branchTake=1 and jumpTake=1, brAddr=0020, jumpAddr=0200 → pc=0200 and err=1, which stays 1 until rst.
- halt=1 at pc=0030 → halted=1, fetchEn=0, pc stays 0030 for 10 cycles despite branchTake pulses. Mid-run rst → pc=0000 asynchronously.
- With PC_SEQ_ALIGN_CHECK_EN defined, jumpAddr=0051 → pc=0050, err=1. Without the macro → pc=0051, err=0.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch PC sequencer: state encodings,
// reset PC default and the fixed instruction size.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    FLUSH  = 2'b01,
    HALTED = 2'b10
  } pcState_t;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
  localparam int          INSTR_SIZE       = 2;
  localparam int          FLUSH_CTR_WIDTH  = 3;

endpackage

// File: rtl/cla_16b.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups with
// lookahead carries between groups. Carry-out is not produced because
// the only user wraps silently.
module cla_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  blkC;
  logic [2:0]  blkG;
  logic [2:0]  blkP;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate, inter-group carries, then per-bit carries.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    blkC = '0;
    blkG = '0;
    blkP = '0;
    c    = '0;
    blkC[0] = cin;
    for (int k = 0; k < 3; k++) begin
      blkG[k] = g[4*k+3]
              | (p[4*k+3] & g[4*k+2])
              | (p[4*k+3] & p[4*k+2] & g[4*k+1])
              | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      blkP[k] = &p[4*k +: 4];
      blkC[k+1] = blkG[k] | (blkP[k] & blkC[k]);
    end
    for (int k = 0; k < 4; k++) begin
      c[4*k]   = blkC[k];
      c[4*k+1] = g[4*k] | (p[4*k] & blkC[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & blkC[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & blkC[k]);
    end
  end

  assign sum = p ^ c;

endmodule

// File: rtl/pc_seq_flush_ctr.sv
// Flush bubble down-counter: load wins over decrement, decrement
// saturates at zero, zero flag is decoded from the stored count.
module pc_seq_flush_ctr #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] loadVal,
  input  logic             decEn,
  output logic [WIDTH-1:0] count,
  output logic             isZero
);

  logic [WIDTH-1:0] countQ;

  // Count register: reload on redirect, otherwise step down toward zero.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      countQ <= '0;
    end else if (load) begin
      countQ <= loadVal;
    end else if (decEn && (countQ != '0)) begin
      countQ <= countQ - 1'b1;
    end
  end

  assign count  = countQ;
  assign isZero = (countQ == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: owns the architectural fetch PC and chooses its
// next value each cycle (redirect > halt > stall > increment), drives
// the pipeline flush and fetch-enable controls, and records sequencing
// errors. Optional build macro PC_SEQ_ALIGN_CHECK_EN: when defined, a
// redirect to an odd target flags err and the target is loaded with
// bit 0 cleared; when undefined, targets are loaded unmodified.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                  PC_WIDTH    = 16,
  parameter int                  FLUSH_DEPTH = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branchTake,
  input  logic [PC_WIDTH-1:0] brAddr,
  input  logic                jumpTake,
  input  logic [PC_WIDTH-1:0] jumpAddr,
  input  logic                halt,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pcPlus2,
  output logic                flush,
  output logic                fetchEn,
  output logic                halted,
  output logic                err
);

  localparam logic [FLUSH_CTR_WIDTH-1:0] FLUSH_RELOAD = FLUSH_CTR_WIDTH'(FLUSH_DEPTH - 1);

  pcState_t                   state;
  pcState_t                   nextState;
  logic [PC_WIDTH-1:0]        pcQ;
  logic [PC_WIDTH-1:0]        nextPc;
  logic [PC_WIDTH-1:0]        rawTarget;
  logic [PC_WIDTH-1:0]        target;
  logic                       active;
  logic                       redirect;
  logic                       misaligned;
  logic                       conflict;
  logic                       errQ;
  logic                       haltedQ;
  logic                       ctrLoad;
  logic                       ctrDec;
  logic [FLUSH_CTR_WIDTH-1:0] flushCount;
  logic                       flushZero;

  // Inputs only matter while sequencing; once halted everything is ignored.
  assign active    = (state == RUN) || (state == FLUSH);
  assign redirect  = active && (branchTake || jumpTake);
  assign conflict  = active && branchTake && jumpTake;
  // Jump wins when both resolve together.
  assign rawTarget = jumpTake ? jumpAddr : brAddr;

`ifdef PC_SEQ_ALIGN_CHECK_EN
  assign misaligned = redirect && rawTarget[0];
  assign target     = {rawTarget[PC_WIDTH-1:1], 1'b0};
`else
  assign misaligned = 1'b0;
  assign target     = rawTarget;
`endif

  // Sequential PC + 2; the 16-bit case reuses the shared CLA.
  if (PC_WIDTH == 16) begin : gCla
    cla_16b uAdd (
      .a   (pcQ),
      .b   (16'(INSTR_SIZE)),
      .cin (1'b0),
      .sum (pcPlus2)
    );
  end else begin : gAdd
    assign pcPlus2 = pcQ + PC_WIDTH'(INSTR_SIZE);
  end

  pc_seq_flush_ctr #(
    .WIDTH (FLUSH_CTR_WIDTH)
  ) uFlushCtr (
    .clk     (clk),
    .rst     (rst),
    .load    (ctrLoad),
    .loadVal (FLUSH_RELOAD),
    .decEn   (ctrDec),
    .count   (flushCount),
    .isZero  (flushZero)
  );

  // Next-state, next-PC and flush-counter control in priority order.
  always_comb begin
    nextState = state;
    nextPc    = pcQ;
    ctrLoad   = 1'b0;
    ctrDec    = 1'b0;
    case (state)
      RUN, FLUSH: begin
        if (redirect) begin
          nextPc    = target;
          nextState = FLUSH;
          ctrLoad   = 1'b1;
        end else if (halt) begin
          nextState = HALTED;
        end else if (!stall) begin
          nextPc = pcPlus2;
          if (state == FLUSH) begin
            ctrDec = !flushZero;
            // Leave once the last bubble cycle has been spent.
            if (flushZero || (flushCount == FLUSH_CTR_WIDTH'(1))) begin
              nextState = RUN;
            end
          end
        end
      end
      HALTED: begin
        nextState = HALTED;
      end
      default: begin
        nextState = RUN;
      end
    endcase
  end

  // State, PC and sticky status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      pcQ     <= RESET_PC;
      errQ    <= 1'b0;
      haltedQ <= 1'b0;
    end else begin
      state   <= nextState;
      pcQ     <= nextPc;
      errQ    <= errQ || conflict || misaligned;
      haltedQ <= (nextState == HALTED);
    end
  end

  assign pc      = pcQ;
  assign halted  = haltedQ;
  assign err     = errQ;
  assign flush   = redirect || ((state == FLUSH) && !flushZero);
  assign fetchEn = !rst && active;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer. The driver applies one vector per
// cycle and queues the hand-computed response for that cycle; the
// monitor pops and compares at the falling edge.
module tb_pc_sequencer;

  typedef struct {
    string       name;
    logic [15:0] pc;
    logic        flush;
    logic        fetchEn;
    logic        halted;
    logic        err;
  } expEntry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        branchTake = 1'b0;
  logic [15:0] brAddr = '0;
  logic        jumpTake = 1'b0;
  logic [15:0] jumpAddr = '0;
  logic        halt = 1'b0;
  logic [15:0] pc;
  logic [15:0] pcPlus2;
  logic        flush;
  logic        fetchEn;
  logic        halted;
  logic        err;

  expEntry_t sbq[$];
  int nCompared   = 0;
  int nMismatched = 0;

`ifdef PC_SEQ_ALIGN_CHECK_EN
  localparam logic [15:0] ALIGN_PC  = 16'h0050;
  localparam logic        ALIGN_ERR = 1'b1;
`else
  localparam logic [15:0] ALIGN_PC  = 16'h0051;
  localparam logic        ALIGN_ERR = 1'b0;
`endif

  pc_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .branchTake (branchTake),
    .brAddr     (brAddr),
    .jumpTake   (jumpTake),
    .jumpAddr   (jumpAddr),
    .halt       (halt),
    .pc         (pc),
    .pcPlus2    (pcPlus2),
    .flush      (flush),
    .fetchEn    (fetchEn),
    .halted     (halted),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    nCompared++;
    if (act !== expv) begin
      nMismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // One cycle of stimulus plus the response expected during that cycle.
  task automatic step(input logic r, input logic s, input logic bt, input logic [15:0] ba,
                      input logic jt, input logic [15:0] ja, input logic h,
                      input logic [15:0] ePc, input logic eFl, input logic eFe,
                      input logic eH, input logic eE, input string nm);
    expEntry_t e;
    @(posedge clk);
    #1;
    rst = r; stall = s; branchTake = bt; brAddr = ba;
    jumpTake = jt; jumpAddr = ja; halt = h;
    e.name = nm; e.pc = ePc; e.flush = eFl; e.fetchEn = eFe; e.halted = eH; e.err = eE;
    sbq.push_back(e);
  endtask

  // Monitor: compare whatever the DUT presents against the queued entry.
  initial begin
    expEntry_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check({e.name, ".pc"},      pc,              e.pc);
        check({e.name, ".pcPlus2"}, pcPlus2,         e.pc + 16'd2);
        check({e.name, ".flush"},   16'(flush),      16'(e.flush));
        check({e.name, ".fetchEn"}, 16'(fetchEn),    16'(e.fetchEn));
        check({e.name, ".halted"},  16'(halted),     16'(e.halted));
        check({e.name, ".err"},     16'(err),        16'(e.err));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //   rst stl br  brAddr    jt  jumpAddr  hlt  expPc     fl fe h  e
    step(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, "reset");
    step(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 0, "run0");
    step(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0002, 0, 1, 0, 0, "run1");
    step(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0004, 0, 1, 0, 0, "run2");
    step(0, 0, 1, 16'h0040, 0, 16'h0000, 0, 16'h0006, 1, 1, 0, 0, "brRedirect");
    step(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0040, 1, 1, 0, 0, "brFlush");
    step(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0042, 0, 1, 0, 0, "brBackToRun");
    step(0, 0, 0, 16'h0000, 1, 16'h0010, 0, 16'h0044, 1, 1, 0, 0, "jmpTo0010");
    step(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0010, 1, 1, 0, 0, "stall1");
    step(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0010, 1, 1, 0, 0, "stall2");
    step(0, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0010, 1, 1, 0, 0, "stall3");
    step(0, 1, 0, 16'h0000, 1, 16'h0100, 0, 16'h0010, 1, 1, 0, 0, "stallPlusJump");
    step(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0100, 1, 1, 0, 0, "jumpOverStall");
    step(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0102, 0, 1, 0, 0, "afterJump");
    step(0, 0, 1, 16'h0020, 1, 16'h0200, 0, 16'h0104, 1, 1, 0, 0, "bothTaken");
    step(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0200, 1, 1, 0, 1, "jumpWins");
    step(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0202, 0, 1, 0, 1, "errSticky");
    step(0, 0, 1, 16'h0030, 0, 16'h0000, 0, 16'h0204, 1, 1, 0, 1, "brTo0030");
    step(0, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0030, 1, 1, 0, 1, "haltInFlush");
    for (int i = 0; i < 10; i++) begin
      step(0, i[1], i[0], 16'h0066, logic'(i == 5), 16'h0300, i[2],
           16'h0030, 0, 0, 1, 1, "haltedHold");
    end
    step(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, "asyncRst");
    step(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, 0, "rstRelease");
    step(0, 0, 0, 16'h0000, 1, 16'h0051, 0, 16'h0002, 1, 1, 0, 0, "jmpOdd");
    step(0, 0, 0, 16'h0000, 0, 16'h0000, 0, ALIGN_PC, 1, 1, 0, ALIGN_ERR, "alignTarget");
    step(0, 0, 0, 16'h0000, 1, 16'hFFFE, 0, ALIGN_PC + 16'd2, 1, 1, 0, ALIGN_ERR, "jmpTop");
    step(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'hFFFE, 1, 1, 0, ALIGN_ERR, "topOfSpace");
    step(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 1, 0, ALIGN_ERR, "wrap");
    step(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0002, 0, 1, 0, ALIGN_ERR, "afterWrap");
    @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboardDrained", 16'(sbq.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
